// File: rtl/cr_fifo_wrap3_pkg.sv
// Shared definitions for the cr_fifo_wrap3 FIFO wrapper: count-width helper
// and parameter legality checks used at elaboration time.
package cr_fifo_wrap3_pkg;

    // Occupancy counters need one extra bit so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Legal configuration: power-of-two DEPTH >= 4, DATA_W >= 1, thresholds inside [0, DEPTH).
    function automatic bit params_ok(input int data_w, input int depth,
                                     input int afull_th, input int aempty_th);
        return (data_w >= 1) && (depth >= 4) && is_pow2(depth) &&
               (afull_th >= 0) && (afull_th < depth) &&
               (aempty_th >= 0) && (aempty_th < depth);
    endfunction

endpackage

// File: rtl/cr_fifo_wrap3_ram.sv
// Simple dual-port 1R1W storage for cr_fifo_wrap3. Synchronous write,
// registered read port; the read register is the FIFO's rdata output.
// Kept free of FIFO control so it can later be swapped for a compiled memory.
module cr_fifo_wrap3_ram #(
    parameter int DATA_W = 71,
    parameter int DEPTH  = 2048,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cr_fifo_wrap3.sv
// cr_fifo_wrap3: parametrised single-clock FIFO with registered status,
// programmable almost-full/almost-empty, synchronous flush and sticky
// overflow/underflow flags. Define CR_FIFO_WRAP3_STATS_EN to add the
// high-water-mark output hwm.
module cr_fifo_wrap3
    import cr_fifo_wrap3_pkg::*;
#(
    parameter int DATA_W    = 71,
    parameter int DEPTH     = 2048,
    parameter int AFULL_TH  = 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wen,
    input  logic                     ren,
    input  logic                     clear,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     afull,
    output logic                     aempty,
    output logic [$clog2(DEPTH):0]   used_slots,
    output logic [$clog2(DEPTH):0]   free_slots,
    output logic                     overflow,
    output logic                     underflow
`ifdef CR_FIFO_WRAP3_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]   hwm
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    generate
        if (!params_ok(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
            $error("cr_fifo_wrap3: illegal DATA_W/DEPTH/threshold configuration");
        end
    endgenerate

    logic [AW-1:0]    wptr_q, rptr_q;
    logic             wr_acc, rd_acc, ovf_ev, unf_ev;
    logic [CNT_W-1:0] used_nxt, free_nxt;

    // Accept/reject decisions against the pre-edge registered flags; flush masks everything.
    always_comb begin
        wr_acc   = wen && !full  && !clear;
        rd_acc   = ren && !empty && !clear;
        ovf_ev   = wen && full   && !clear;
        unf_ev   = ren && empty  && !clear;
        used_nxt = clear ? '0 : used_slots + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        free_nxt = CNT_W'(DEPTH) - used_nxt;
    end

    // Pointers, count and status flags, all derived from the next count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            used_slots <= '0;
            free_slots <= CNT_W'(DEPTH);
            full       <= 1'b0;
            empty      <= 1'b1;
            afull      <= 1'b0;
            aempty     <= 1'b1;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + AW'(1);
            if (rd_acc) rptr_q <= rptr_q + AW'(1);
            used_slots <= used_nxt;
            free_slots <= free_nxt;
            full       <= (used_nxt == CNT_W'(DEPTH));
            empty      <= (used_nxt == '0);
            afull      <= (free_nxt <= CNT_W'(AFULL_TH));
            aempty     <= (used_nxt <= CNT_W'(AEMPTY_TH));
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || ovf_ev;
            underflow <= (underflow && !clr_err) || unf_ev;
        end
    end

`ifdef CR_FIFO_WRAP3_STATS_EN
    // High-water mark survives flush; only clr_err or reset clear it.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_err)   hwm <= '0;
        else if (used_nxt > hwm) hwm <= used_nxt;
    end
`endif

    cr_fifo_wrap3_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_acc),
        .waddr  (wptr_q),
        .wdata  (wdata),
        .re     (rd_acc),
        .raddr  (rptr_q),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_cr_fifo_wrap3.sv
// Self-checking bench for cr_fifo_wrap3 (DEPTH=8, DATA_W=16, AFULL_TH=2,
// AEMPTY_TH=1): directed test-plan sequences followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_cr_fifo_wrap3;

    localparam int DATA_W    = 16;
    localparam int DEPTH     = 8;
    localparam int AFULL_TH  = 2;
    localparam int AEMPTY_TH = 1;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic              wen = 1'b0, ren = 1'b0, clear = 1'b0, clr_err = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              full, empty, afull, aempty, overflow, underflow;
    logic [CNT_W-1:0]  used_slots, free_slots;
`ifdef CR_FIFO_WRAP3_STATS_EN
    logic [CNT_W-1:0]  hwm;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rdata = '0;
    bit                m_ovf = 0, m_unf = 0;
    int                m_hwm = 0;

    always #5 clk = ~clk;

    cr_fifo_wrap3 #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wdata      (wdata),
        .wen        (wen),
        .ren        (ren),
        .clear      (clear),
        .clr_err    (clr_err),
        .rdata      (rdata),
        .full       (full),
        .empty      (empty),
        .afull      (afull),
        .aempty     (aempty),
        .used_slots (used_slots),
        .free_slots (free_slots),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef CR_FIFO_WRAP3_STATS_EN
        ,
        .hwm        (hwm)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Apply one cycle of stimulus, advance the model, then compare every output.
    task automatic step(input bit rst, input bit w, input bit r, input bit clr,
                        input bit ce, input logic [DATA_W-1:0] d);
        int n;
        @(negedge clk);
        rst_n = ~rst; wen = w; ren = r; clear = clr; clr_err = ce; wdata = d;
        @(posedge clk);
        n = q.size();
        if (rst) begin
            q.delete(); m_rdata = '0; m_ovf = 0; m_unf = 0; m_hwm = 0;
        end else begin
            if (clr) begin
                q.delete();
            end else begin
                if (r && n > 0) m_rdata = q.pop_front();
                if (w && n < DEPTH) q.push_back(d);
            end
            m_ovf = (m_ovf && !ce) || (!clr && w && n == DEPTH);
            m_unf = (m_unf && !ce) || (!clr && r && n == 0);
            if (ce) m_hwm = 0;
            else if (q.size() > m_hwm) m_hwm = q.size();
        end
        #1;
        n = q.size();
        chk("rdata",     32'(rdata),      32'(m_rdata));
        chk("used",      32'(used_slots), 32'(n));
        chk("free",      32'(free_slots), 32'(DEPTH - n));
        chk("full",      32'(full),       32'(n == DEPTH));
        chk("empty",     32'(empty),      32'(n == 0));
        chk("afull",     32'(afull),      32'((DEPTH - n) <= AFULL_TH));
        chk("aempty",    32'(aempty),     32'(n <= AEMPTY_TH));
        chk("overflow",  32'(overflow),   32'(m_ovf));
        chk("underflow", 32'(underflow),  32'(m_unf));
`ifdef CR_FIFO_WRAP3_STATS_EN
        chk("hwm",       32'(hwm),        32'(m_hwm));
`endif
    endtask

    task automatic wr(input logic [DATA_W-1:0] d); step(0, 1, 0, 0, 0, d); endtask
    task automatic rd();                           step(0, 0, 1, 0, 0, '0); endtask
    task automatic idle();                         step(0, 0, 0, 0, 0, '0); endtask
    task automatic cerr();                         step(0, 0, 0, 0, 1, '0); endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        chk("rst_free_const", 32'(free_slots), 32'(DEPTH));
        chk("rst_rdata_const", 32'(rdata), 32'h0);

        // Fill, including afull after 6th and full after 8th write
        for (int i = 1; i <= DEPTH; i++) begin
            wr(DATA_W'(i));
            if (i == 6) chk("afull_at6", 32'(afull), 32'h1);
            if (i == 7) chk("full_at7", 32'(full), 32'h0);
        end
        chk("full_at8", 32'(full), 32'h1);
        wr(16'h0009);
        chk("ovf_9th", 32'(overflow), 32'h1);
        chk("used_9th", 32'(used_slots), 32'(DEPTH));

        // Drain: each read returns its value one cycle after ren
        for (int i = 1; i <= DEPTH; i++) begin
            rd();
            chk("drain_data", 32'(rdata), 32'(i));
        end
        chk("empty_drain", 32'(empty), 32'h1);
        rd();
        chk("unf_extra", 32'(underflow), 32'h1);
        chk("rdata_hold", 32'(rdata), 32'h8);

        // Boundaries: wen+ren at full, then at empty
        cerr();
        for (int i = 0; i < DEPTH; i++) wr(DATA_W'(16'h100 + i));
        step(0, 1, 1, 0, 0, 16'hBEEF);
        chk("bnd_full_used", 32'(used_slots), 32'(DEPTH - 1));
        chk("bnd_full_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH - 1; i++) rd();
        step(0, 1, 1, 0, 0, 16'hCAFE);
        chk("bnd_empty_used", 32'(used_slots), 32'h1);
        chk("bnd_empty_unf", 32'(underflow), 32'h1);
        rd();
        chk("bnd_empty_data", 32'(rdata), 32'hCAFE);

        // Flush after pointer wrap: 12 writes, 10 reads
        cerr();
        for (int i = 0; i < 8; i++) wr(DATA_W'(16'h200 + i));
        for (int i = 0; i < 6; i++) rd();
        for (int i = 8; i < 12; i++) wr(DATA_W'(16'h200 + i));
        for (int i = 0; i < 4; i++) rd();
        step(0, 1, 1, 1, 0, 16'hDEAD);
        chk("flush_used", 32'(used_slots), 32'h0);
        chk("flush_no_ovf", 32'(overflow), 32'h0);
        chk("flush_no_unf", 32'(underflow), 32'h0);
        wr(16'h1234);
        rd();
        chk("flush_data", 32'(rdata), 32'h1234);

        // High-water mark survives clear, cleared by clr_err
        cerr();
        for (int i = 0; i < 5; i++) wr(DATA_W'(i));
        for (int i = 0; i < 5; i++) rd();
        step(0, 0, 0, 1, 0, '0);
        idle();
`ifdef CR_FIFO_WRAP3_STATS_EN
        chk("hwm_after_clear", 32'(hwm), 32'h5);
`endif
        cerr();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(99) < 55,
                 $urandom_range(99) < 50,
                 $urandom_range(39) == 0,
                 $urandom_range(19) == 0,
                 DATA_W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
